// File: rtl/simple_dmem.sv
// 256x8 single-port data memory with fixed wait states,
// a write-protected upper region and saturating access counters.
module simple_dmem #(
    parameter int unsigned LAT     = 2,
    parameter logic [7:0]  RO_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_req,
    input  logic       mem_we,
    input  logic [7:0] mem_addr,
    input  logic [7:0] mem_wdata,
    output logic [7:0] mem_rdata,
    output logic       mem_ready,
    output logic       err,
    output logic [7:0] rd_cnt,
    output logic [7:0] wr_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;

    logic [7:0] rdata_q;
    logic       ready_q;
    logic       err_q;
    logic [7:0] rd_cnt_q;
    logic [7:0] wr_cnt_q;
    logic [7:0] mem_q [256];

    logic [7:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       acc_we;
    logic       enter_resp;
    logic       ro_hit;
    logic       do_load;
    logic       do_store;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        acc_addr   = addr_q;
        acc_we     = we_q;
        acc_wdata  = wdata_q;
        unique case (state_q)
            IDLE: begin
                // With zero wait states the access completes on the
                // accept edge, so it must act on the live inputs.
                acc_addr  = mem_addr;
                acc_we    = mem_we;
                acc_wdata = mem_wdata;
                if (mem_req) begin
                    addr_d  = mem_addr;
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    if (LAT == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = 4'(LAT);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ro_hit   = (acc_addr >= RO_BASE);
    assign do_load  = enter_resp & ~acc_we;
    assign do_store = enter_resp & acc_we & ~ro_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 8'd0;
            we_q     <= 1'b0;
            wdata_q  <= 8'd0;
            rdata_q  <= 8'd0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= 8'd0;
            wr_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ready_q <= enter_resp;
            err_q   <= enter_resp & acc_we & ro_hit;
            if (do_load) begin
                rdata_q <= mem_q[acc_addr];
            end
            if (do_load && rd_cnt_q != 8'hFF) begin
                rd_cnt_q <= rd_cnt_q + 8'd1;
            end
            if (do_store && wr_cnt_q != 8'hFF) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else if (do_store) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign err       = err_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_simple_dmem.sv
// Directed bench for simple_dmem: a LAT=2 instance and a LAT=0
// instance, with a reference memory model and response scoreboard.
module tb_simple_dmem;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       mem_req = 1'b0;
    logic       mem_we = 1'b0;
    logic [7:0] mem_addr = 8'd0;
    logic [7:0] mem_wdata = 8'd0;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       err;
    logic [7:0] rd_cnt;
    logic [7:0] wr_cnt;

    logic       req0 = 1'b0;
    logic       we0 = 1'b0;
    logic [7:0] addr0 = 8'd0;
    logic [7:0] wdata0 = 8'd0;
    logic [7:0] rdata0;
    logic       ready0;
    logic       err0;
    logic [7:0] rdc0;
    logic [7:0] wrc0;

    int checks = 0;
    int errors = 0;

    exp_t       q[$];
    exp_t       q0[$];
    logic [7:0] model [256];
    logic [7:0] last_rd;
    int         rd_m;
    int         wr_m;

    simple_dmem #(.LAT(2), .RO_BASE(8'hF0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    simple_dmem #(.LAT(0), .RO_BASE(8'hF0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (req0),
        .mem_we    (we0),
        .mem_addr  (addr0),
        .mem_wdata (wdata0),
        .mem_rdata (rdata0),
        .mem_ready (ready0),
        .err       (err0),
        .rd_cnt    (rdc0),
        .wr_cnt    (wrc0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model[i] = 8'd0;
        last_rd = 8'd0;
        rd_m    = 0;
        wr_m    = 0;
    endtask

    // Called at a negedge in an IDLE cycle; returns at the negedge
    // of the IDLE cycle following the response.
    task automatic access(input logic we, input logic [7:0] a,
                          input logic [7:0] d);
        exp_t e;
        int   n;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        e.err = 1'b0;
        if (we) begin
            if (a < 8'hF0) begin
                model[a] = d;
                if (wr_m < 255) wr_m++;
            end else begin
                e.err = 1'b1;
            end
        end else begin
            last_rd = model[a];
            if (rd_m < 255) rd_m++;
        end
        e.rdata = last_rd;
        q.push_back(e);
        @(negedge clk);
        mem_req   = 1'b0;
        mem_we    = 1'($urandom);
        mem_addr  = 8'($urandom);
        mem_wdata = 8'($urandom);
        n = 1;
        while (!mem_ready && n < 20) begin
            chk("err_early", {7'd0, err}, 8'd0);
            @(negedge clk);
            n++;
        end
        chk("ready_seen", {7'd0, mem_ready}, 8'd1);
        chk("latency", 8'(n), 8'd3);
        e = q.pop_front();
        chk("rdata", mem_rdata, e.rdata);
        chk("err", {7'd0, err}, {7'd0, e.err});
        chk("rd_cnt", rd_cnt, 8'(rd_m));
        chk("wr_cnt", wr_cnt, 8'(wr_m));
        @(negedge clk);
        chk("ready_pulse", {7'd0, mem_ready}, 8'd0);
        chk("err_pulse", {7'd0, err}, 8'd0);
        chk("rdata_hold", mem_rdata, last_rd);
    endtask

    initial begin
        exp_t e0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdata", mem_rdata, 8'd0);
        chk("rst_ready", {7'd0, mem_ready}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_rdcnt", rd_cnt, 8'd0);
        chk("rst_wrcnt", wr_cnt, 8'd0);
        chk("rst0_ready", {7'd0, ready0}, 8'd0);
        chk("rst0_rdcnt", rdc0, 8'd0);

        // LAT=0: mem_req held high over 4 stores then 4 loads
        req0   = 1'b1;
        we0    = 1'b1;
        addr0  = 8'd1;
        wdata0 = 8'h11;
        q0.push_back('{rdata: 8'h00, err: 1'b0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("z_ready", {7'd0, ready0}, 8'd1);
            e0 = q0.pop_front();
            chk("z_rdata", rdata0, e0.rdata);
            chk("z_err", {7'd0, err0}, {7'd0, e0.err});
            if (i < 7) begin
                if (i + 1 < 4) begin
                    we0    = 1'b1;
                    addr0  = 8'(i + 2);
                    wdata0 = 8'(8'h11 * (i + 2));
                    q0.push_back('{rdata: 8'h00, err: 1'b0});
                end else begin
                    we0    = 1'b0;
                    addr0  = 8'(i - 2);
                    wdata0 = 8'($urandom);
                    q0.push_back('{rdata: 8'(8'h11 * (i - 2)),
                                   err: 1'b0});
                end
            end else begin
                req0 = 1'b0;
            end
            @(negedge clk);
            chk("z_gap", {7'd0, ready0}, 8'd0);
        end
        chk("z_rdcnt", rdc0, 8'd4);
        chk("z_wrcnt", wrc0, 8'd4);

        access(1'b0, 8'h00, 8'h00);
        access(1'b1, 8'h10, 8'h5A);
        access(1'b0, 8'h10, 8'h00);
        access(1'b1, 8'hF0, 8'hAA);
        access(1'b0, 8'hF0, 8'h00);
        access(1'b1, 8'hEF, 8'h33);
        access(1'b0, 8'hEF, 8'h00);
        access(1'b1, 8'hFF, 8'h12);
        access(1'b0, 8'hFF, 8'h00);

        // reset in the first WAIT cycle of a store
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 8'h20;
        mem_wdata = 8'h77;
        @(negedge clk);
        mem_req = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            chk("rw_noready", {7'd0, mem_ready}, 8'd0);
            @(negedge clk);
        end
        chk("rw_rdcnt", rd_cnt, 8'd0);
        chk("rw_wrcnt", wr_cnt, 8'd0);
        chk("rw_rdata", mem_rdata, 8'd0);
        access(1'b0, 8'h20, 8'h00);
        access(1'b0, 8'h10, 8'h00);

        access(1'b1, 8'h42, 8'hC3);
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            access(1'b0, 8'(i), 8'h00);
        end
        chk("sat_rdcnt", rd_cnt, 8'hFF);
        chk("sat_wrcnt", wr_cnt, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
